// File: rtl/i2s_rx_packer.sv
// Packs I2S RX samples (32/2x16/4x8 bits) into 32-bit words for the uDMA RX FIFO.
// Optional feature macro: I2S_RX_PACKER_SIGN_EXT_EN (sign-extend 32-bit-mode samples from cfg_wlen_i).
module i2s_rx_packer (
   input  logic        sck_i,
   input  logic        rstn_i,
   input  logic [31:0] in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic [31:0] out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   input  logic        cfg_en_i,
   input  logic [1:0]  cfg_pack_i,
   input  logic [4:0]  cfg_wlen_i,
   input  logic        cfg_flush_i,
   output logic        overrun_o
);

   logic [1:0]  lane_q, lane_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        overrun_q, overrun_d;
   logic        flush_pend_q, flush_pend_d;

   logic [1:0]  last_lane_s;
   logic [31:0] sample_s;
   logic [31:0] merged_s;
   logic        ready_s;
   logic        accept_s;
   logic        out_free_s;

   // Index of the lane that completes a word in the current packing mode.
   always_comb begin
      case (cfg_pack_i)
         2'd1:    last_lane_s = 2'd1;
         2'd2:    last_lane_s = 2'd3;
         default: last_lane_s = 2'd0;
      endcase
   end

`ifdef I2S_RX_PACKER_SIGN_EXT_EN
   // Sample conditioning: sign extension above cfg_wlen_i in 32-bit mode only.
   always_comb begin
      sample_s = in_data_i;
      if ((cfg_pack_i == 2'd0) || (cfg_pack_i == 2'd3)) begin
         for (int i = 0; i < 32; i++) begin
            if (5'(i) > cfg_wlen_i) begin
               sample_s[i] = in_data_i[cfg_wlen_i];
            end else begin
               sample_s[i] = in_data_i[i];
            end
         end
      end else begin
         sample_s = in_data_i;
      end
   end
`else
   logic unused_wlen_s;
   assign unused_wlen_s = ^cfg_wlen_i;
   assign sample_s      = in_data_i;
`endif

   // Accumulator with the incoming sample merged into the current lane.
   always_comb begin
      merged_s = acc_q;
      case (cfg_pack_i)
         2'd1: begin
            if (lane_q[0]) begin
               merged_s[31:16] = sample_s[15:0];
            end else begin
               merged_s[15:0] = sample_s[15:0];
            end
         end
         2'd2: begin
            case (lane_q)
               2'd0:    merged_s[7:0]   = sample_s[7:0];
               2'd1:    merged_s[15:8]  = sample_s[7:0];
               2'd2:    merged_s[23:16] = sample_s[7:0];
               default: merged_s[31:24] = sample_s[7:0];
            endcase
         end
         default: merged_s = sample_s;
      endcase
   end

   // The final lane is blocked only while the output register is full and not draining.
   assign out_free_s = ~out_valid_q | out_ready_i;
   assign ready_s    = cfg_en_i & ~flush_pend_q &
                       ~((lane_q == last_lane_s) & out_valid_q & ~out_ready_i);
   assign accept_s   = in_valid_i & ready_s;

   // Next-state: packing, completion, flush and output handshake.
   always_comb begin
      lane_d       = lane_q;
      acc_d        = acc_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      flush_pend_d = flush_pend_q;
      overrun_d    = in_valid_i & cfg_en_i & ~ready_s;

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      if (!cfg_en_i) begin
         lane_d       = 2'd0;
         acc_d        = 32'd0;
         flush_pend_d = 1'b0;
      end else if (accept_s && (lane_q == last_lane_s)) begin
         // A completing accept makes any simultaneous flush redundant.
         out_data_d   = merged_s;
         out_valid_d  = 1'b1;
         lane_d       = 2'd0;
         acc_d        = 32'd0;
         flush_pend_d = 1'b0;
      end else begin
         if (accept_s) begin
            acc_d  = merged_s;
            lane_d = lane_q + 2'd1;
         end else begin
            acc_d  = acc_q;
            lane_d = lane_q;
         end
         if (cfg_flush_i || flush_pend_q) begin
            if (lane_q == 2'd0) begin
               flush_pend_d = 1'b0;
            end else if (out_free_s) begin
               out_data_d   = accept_s ? merged_s : acc_q;
               out_valid_d  = 1'b1;
               lane_d       = 2'd0;
               acc_d        = 32'd0;
               flush_pend_d = 1'b0;
            end else begin
               flush_pend_d = 1'b1;
            end
         end else begin
            flush_pend_d = flush_pend_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge sck_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lane_q       <= 2'd0;
         acc_q        <= 32'd0;
         out_data_q   <= 32'd0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         lane_q       <= lane_d;
         acc_q        <= acc_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign in_ready_o  = ready_s;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_i2s_rx_packer.sv
// Scoreboard bench for i2s_rx_packer: a sample-list model predicts packed words, ready and overrun.
module tb_i2s_rx_packer;

   logic        sck_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic [31:0] in_data_i = 32'd0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic        cfg_en_i = 1'b0;
   logic [1:0]  cfg_pack_i = 2'd0;
   logic [4:0]  cfg_wlen_i = 5'd31;
   logic        cfg_flush_i = 1'b0;
   logic        overrun_o;

   int n_checks = 0;
   int n_errors = 0;

   // model state as seen after the last clock edge, and its prediction for the next edge
   logic [31:0] m_q[$];
   bit          m_full, m_pend, m_ovr;
   logic [31:0] n_q[$];
   bit          n_full, n_pend, n_ovr, n_load;
   logic [31:0] n_word;
   logic [31:0] exp_q[$];

   i2s_rx_packer dut (
      .sck_i(sck_i), .rstn_i(rstn_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .cfg_en_i(cfg_en_i), .cfg_pack_i(cfg_pack_i),
      .cfg_wlen_i(cfg_wlen_i), .cfg_flush_i(cfg_flush_i), .overrun_o(overrun_o)
   );

   always #5 sck_i = ~sck_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lanes(input logic [1:0] p);
      return (p == 2'd1) ? 2 : (p == 2'd2) ? 4 : 1;
   endfunction

   function automatic logic [31:0] prep(input logic [31:0] d, input logic [1:0] p, input logic [4:0] wl);
      logic signed [31:0] t;
      int sh;
      if (p == 2'd1) return d & 32'h0000_FFFF;
      if (p == 2'd2) return d & 32'h0000_00FF;
`ifdef I2S_RX_PACKER_SIGN_EXT_EN
      sh = 31 - int'(wl);
      t  = signed'(d << sh);
      return t >>> sh;
`else
      sh = int'(wl);
      t  = signed'(d);
      return (sh >= 0) ? t : 32'd0;
`endif
   endfunction

   function automatic logic [31:0] pack(input logic [31:0] q[$], input logic [1:0] p);
      logic [31:0] w;
      int lw;
      w  = 32'd0;
      lw = 32 / lanes(p);
      for (int k = 0; k < q.size(); k++) w = w | (q[k] << (lw * k));
      return w;
   endfunction

   task automatic apply_model();
      m_full = n_full;
      m_pend = n_pend;
      m_ovr  = n_ovr;
      m_q    = n_q;
      if (n_load) exp_q.push_back(n_word);
      n_load = 1'b0;
   endtask

   task automatic predict();
      int  nl, pre;
      bit  rdy, acc;
      nl  = lanes(cfg_pack_i);
      rdy = cfg_en_i && !m_pend && !((m_q.size() == nl - 1) && m_full && !out_ready_i);
      check("in_ready", {31'd0, in_ready_o}, {31'd0, rdy});
      acc    = in_valid_i && rdy;
      n_ovr  = in_valid_i && cfg_en_i && !rdy;
      n_q    = m_q;
      n_pend = m_pend;
      n_load = 1'b0;
      n_full = m_full && !out_ready_i;
      if (!cfg_en_i) begin
         n_q.delete();
         n_pend = 1'b0;
      end else begin
         pre = m_q.size();
         if (acc) n_q.push_back(prep(in_data_i, cfg_pack_i, cfg_wlen_i));
         if (acc && n_q.size() >= nl) begin
            n_load = 1'b1; n_word = pack(n_q, cfg_pack_i); n_q.delete(); n_pend = 1'b0;
         end else if (cfg_flush_i || m_pend) begin
            if (pre == 0) n_pend = 1'b0;
            else if (!m_full || out_ready_i) begin
               n_load = 1'b1; n_word = pack(n_q, cfg_pack_i); n_q.delete(); n_pend = 1'b0;
            end else n_pend = 1'b1;
         end
      end
      if (n_load) n_full = 1'b1;
   endtask

   task automatic cycle(input bit v, input logic [31:0] d, input bit fl, input bit ordy, input bit en);
      @(posedge sck_i); #1;
      apply_model();
      in_valid_i = v; in_data_i = d; cfg_flush_i = fl; out_ready_i = ordy; cfg_en_i = en;
      #1;
      predict();
   endtask

   task automatic set_cfg(input logic [1:0] p, input logic [4:0] wl);
      cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      cfg_pack_i = p;
      cfg_wlen_i = wl;
   endtask

   task automatic reset_dut();
      @(posedge sck_i); #1;
      apply_model();
      rstn_i = 1'b0;
      in_valid_i = 1'b0; cfg_flush_i = 1'b0; out_ready_i = 1'b1; cfg_en_i = 1'b1;
      m_q.delete(); n_q.delete(); exp_q.delete();
      m_full = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
      n_full = 1'b0; n_pend = 1'b0; n_ovr = 1'b0; n_load = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_out_data", out_data_o, 32'd0);
      check("rst_overrun", {31'd0, overrun_o}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      rstn_i = 1'b1;
   endtask

   // Monitor: compares every handshaked output word with the scoreboard head.
   initial begin
      forever begin
         @(negedge sck_i);
         if (rstn_i) begin
            check("out_valid", {31'd0, out_valid_o}, {31'd0, m_full});
            check("overrun", {31'd0, overrun_o}, {31'd0, m_ovr});
            if (out_valid_o && out_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL out_word: got %h, expected no word at %0t", out_data_o, $time);
               end else begin
                  check("out_word", out_data_o, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      reset_dut();
      // 4x8 packing
      set_cfg(2'd2, 5'd31);
      cycle(1'b1, 32'h11, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'h22, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'h33, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'h44, 1'b0, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      // 2x16 packing, upper bits discarded
      set_cfg(2'd1, 5'd31);
      cycle(1'b1, 32'hAAAA1234, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'hBBBB5678, 1'b0, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      // back-pressure and overrun
      cycle(1'b1, 32'h0001, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h0002, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h0003, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h0004, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h0005, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h0006, 1'b0, 1'b1, 1'b1);
      repeat (3) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      // flush of a partial word, then a flush with nothing buffered
      set_cfg(2'd2, 5'd31);
      cycle(1'b1, 32'h01, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'h02, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 32'h00, 1'b1, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 32'h00, 1'b1, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      // flush held pending behind a blocked output
      for (int i = 0; i < 6; i++) cycle(1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 32'h00, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 32'hB0, 1'b0, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      // 32-bit mode with wlen 15
      set_cfg(2'd0, 5'd15);
      cycle(1'b1, 32'h00008001, 1'b0, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      // reset in the middle of a word
      set_cfg(2'd2, 5'd31);
      cycle(1'b1, 32'hE1, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'hE2, 1'b0, 1'b1, 1'b1);
      reset_dut();
      cycle(1'b1, 32'hC1, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'hC2, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'hC3, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 32'hC4, 1'b0, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      // randomized segments, reconfiguring only while disabled
      for (int seg = 0; seg < 24; seg++) begin
         set_cfg(2'($urandom_range(0, 3)), 5'($urandom_range(7, 31)));
         for (int c = 0; c < 40; c++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 12) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) != 0);
         end
      end
      repeat (6) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      @(posedge sck_i); #1;
      apply_model();
      @(negedge sck_i); #1;
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
